// File: rtl/sys_pkg.sv
// sys_pkg: shared definitions for the MAC datapath write-back.
//  state_t   FSM state encoding (IDLE/RUN/DONE)
//  ACC_W_DEF default lane result width
//  N_MACS_DEF default lanes per row
//  addr_w()  address width for a given memory depth
package sys_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int ACC_W_DEF = 16;
   localparam int N_MACS_DEF = 4;
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/result_fifo.sv
// result_fifo: synchronous FIFO buffering packed rows ahead of the BRAM write port.
//  clk, rst  clock, synchronous active-high reset
//  clr       synchronous clear (empties the FIFO)
//  push/din  write a word (ignored when full)
//  pop       drop the head word (ignored when empty)
//  dout      head word (valid while !empty)
//  full      DEPTH words stored
//  empty     no words stored
module result_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0] wr_ptr, rd_ptr;
   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign dout = mem[rd_ptr[PW-1:0]];
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[PW-1:0]] <= din;
   end
endmodule

// File: rtl/result_mem_wr.sv
// result_mem_wr: packs MAC lane results into rows and writes them to the output BRAM.
//  clk, rst          clock, synchronous active-high reset
//  start             arm a run (IDLE only): loads base_addr and row_count
//  base_addr         first BRAM word address
//  row_count         rows to write this run (0..MEM_DEPTH)
//  acc_in_0..3       lane results
//  valid_in          per-lane result strobes (lanes may be skewed)
//  bram_addr/en/we   BRAM write port control
//  bram_din          packed row {lane3,lane2,lane1,lane0}
//  busy              high while running
//  done              one-cycle pulse at run completion
//  overflow          sticky lane or FIFO overrun during this run
//  rows_written      rows committed to BRAM this run
module result_mem_wr
   import sys_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int N_MACS = N_MACS_DEF,
   parameter int MEM_DEPTH = 256,
   parameter int FIFO_DEPTH = 4,
   localparam int AW = addr_w(MEM_DEPTH),
   localparam int RW = N_MACS * ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AW-1:0]     base_addr,
   input  logic [AW:0]       row_count,
   input  logic [ACC_W-1:0]  acc_in_0,
   input  logic [ACC_W-1:0]  acc_in_1,
   input  logic [ACC_W-1:0]  acc_in_2,
   input  logic [ACC_W-1:0]  acc_in_3,
   input  logic [N_MACS-1:0] valid_in,
   output logic [AW-1:0]     bram_addr,
   output logic              bram_en,
   output logic              bram_we,
   output logic [RW-1:0]     bram_din,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [AW:0]       rows_written
);
   state_t state, state_nx;
   logic [AW-1:0] addr;
   logic [AW:0] target, rows_pushed;
   logic [N_MACS-1:0] mask, mask_nx, cap;
   logic [N_MACS-1:0][ACC_W-1:0] lane_in, lane_reg;
   logic [RW-1:0] head;
   logic run, clr, full_mask, push, fifo_push, fifo_pop, fifo_full, fifo_empty, cap_en, ovf_set;
   assign lane_in = {acc_in_3, acc_in_2, acc_in_1, acc_in_0};
   always_comb begin
      run = state == RUN;
      clr = state == IDLE && start;
      full_mask = &mask;
      push = run && full_mask;
      fifo_push = push && !fifo_full;
      fifo_pop = run && !fifo_empty;
      // Stop capturing once every row of this run is accounted for, counting a push in flight.
      cap_en = run && ((rows_pushed + {{AW{1'b0}}, fifo_push}) < target);
      // A full mask is being pushed this edge, so new strobes land in a fresh row.
      cap = cap_en ? (valid_in & (full_mask ? {N_MACS{1'b1}} : ~mask)) : '0;
      ovf_set = (cap_en && !full_mask && |(valid_in & mask)) || (push && fifo_full);
      mask_nx = clr ? '0 : run ? ((full_mask ? '0 : mask) | cap) : mask;
      state_nx = clr ? RUN
               : (run && rows_written == target && fifo_empty) ? DONE
               : (state == DONE) ? IDLE
               : state;
      bram_en = fifo_pop;
      bram_we = fifo_pop;
      bram_addr = addr;
      bram_din = fifo_pop ? head : '0;
      busy = run;
      done = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         addr <= '0;
         target <= '0;
         rows_pushed <= '0;
         rows_written <= '0;
         mask <= '0;
         lane_reg <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nx;
         mask <= mask_nx;
         for (int i = 0; i < N_MACS; i++) if (cap[i]) lane_reg[i] <= lane_in[i];
         if (clr) begin
            addr <= base_addr;
            target <= row_count;
            rows_pushed <= '0;
            rows_written <= '0;
            overflow <= 1'b0;
         end else begin
            if (fifo_push) rows_pushed <= rows_pushed + 1'b1;
            if (fifo_pop) begin
               addr <= (addr == AW'(MEM_DEPTH - 1)) ? '0 : addr + 1'b1;
               rows_written <= rows_written + 1'b1;
            end
            if (ovf_set) overflow <= 1'b1;
         end
      end
   end
   result_fifo #(.WIDTH(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .push(fifo_push),
      .pop(fifo_pop),
      .din(lane_reg),
      .dout(head),
      .full(fifo_full),
      .empty(fifo_empty)
   );
endmodule

// File: tb/tb_result_mem_wr.sv
// tb_result_mem_wr: randomized scoreboard bench for result_mem_wr with a row-level reference model.
module tb_result_mem_wr;
   logic clk = 0, rst = 1, start = 0;
   logic [7:0] base_addr = 0;
   logic [8:0] row_count = 0;
   logic [15:0] acc_in_0 = 0, acc_in_1 = 0, acc_in_2 = 0, acc_in_3 = 0;
   logic [3:0] valid_in = 0;
   logic [7:0] bram_addr;
   logic bram_en, bram_we, busy, done, overflow;
   logic [63:0] bram_din;
   logic [8:0] rows_written;
   int total = 0, bad = 0, cyc = 0;

   typedef struct {logic [7:0] a; logic [63:0] d; int c;} exp_t;
   exp_t q[$];
   bit m_on = 0, m_ovf = 0;
   int m_base = 0, m_cnt = 0, m_emit = 0, last_exp = 0;
   logic [15:0] m_val[4];
   bit m_fill[4];

   result_mem_wr dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_count(row_count),
      .acc_in_0(acc_in_0), .acc_in_1(acc_in_1), .acc_in_2(acc_in_2), .acc_in_3(acc_in_3),
      .valid_in(valid_in), .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
      .bram_din(bram_din), .busy(busy), .done(done), .overflow(overflow), .rows_written(rows_written)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", n, act, exp, $time);
      end
   endfunction

   // Monitor: every write strobe must match the oldest expected row.
   always @(negedge clk) begin
      if (bram_en === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write actual=addr %0h data %0h required=no write", bram_addr, bram_din);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("wr_addr", bram_addr, e.a);
            chk("wr_data", bram_din, e.d);
            chk("wr_cycle", cyc, e.c);
            chk("wr_we", bram_we, 1);
         end
      end
   end

   // Row-level model: each lane fills one slot per row; a repeat into a filled slot is lost.
   task automatic step(input logic [3:0] v, input logic [15:0] a0, a1, a2, a3);
      logic [15:0] av[4];
      exp_t e;
      av = '{a0, a1, a2, a3};
      valid_in = v;
      acc_in_0 = a0; acc_in_1 = a1; acc_in_2 = a2; acc_in_3 = a3;
      if (m_on && m_emit < m_cnt) begin
         for (int i = 0; i < 4; i++)
            if (v[i]) begin
               if (m_fill[i]) m_ovf = 1;
               else begin m_fill[i] = 1; m_val[i] = av[i]; end
            end
         if (m_fill[0] && m_fill[1] && m_fill[2] && m_fill[3]) begin
            e.a = 8'((m_base + m_emit) % 256);
            e.d = {m_val[3], m_val[2], m_val[1], m_val[0]};
            e.c = (cyc + 2 > last_exp + 1) ? cyc + 2 : last_exp + 1;
            last_exp = e.c;
            q.push_back(e);
            m_emit++;
            for (int i = 0; i < 4; i++) m_fill[i] = 0;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic start_run(input logic [7:0] b, input int cnt);
      start = 1; base_addr = b; row_count = 9'(cnt); valid_in = 0;
      @(posedge clk); #1;
      start = 0;
      m_on = 1; m_base = b; m_cnt = cnt; m_emit = 0; m_ovf = 0;
      for (int i = 0; i < 4; i++) m_fill[i] = 0;
      chk("run_busy", busy, 1);
      chk("run_ovf_clear", overflow, 0);
   endtask

   task automatic wait_done(input int cnt);
      bit got;
      got = 0;
      valid_in = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL done_timeout actual=no done required=done within 300 cycles");
      end else begin
         chk("done_rows", rows_written, 9'(cnt));
         chk("done_ovf", overflow, m_ovf);
         chk("done_busy", busy, 0);
         @(negedge clk);
         chk("done_pulse", done, 0);
      end
      @(posedge clk); #1;
      chk("q_drained", q.size(), 0);
      m_on = 0;
   endtask

   task automatic rand_row_fill();
      for (int k = 0; k < 200 && m_emit < m_cnt; k++)
         step(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      repeat (3) step(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_en", bram_en, 0);
      chk("rst_addr", bram_addr, 0);
      chk("rst_din", bram_din, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_rows", rows_written, 0);
      rst = 0;
      @(posedge clk); #1;
      // Aligned lanes, two rows.
      start_run(8'h10, 2);
      step(4'hF, 1, 2, 3, 4);
      step(4'hF, 5, 6, 7, 8);
      wait_done(2);
      // Strobes while idle are ignored, then skewed lanes.
      repeat (4) step(4'hF, 16'hdead, 16'hbeef, 16'h1234, 16'h5678);
      start_run(8'h40, 1);
      step(4'h1, 16'h0a0a, 0, 0, 0);
      step(4'h2, 0, 16'h0b0b, 0, 0);
      step(4'h4, 0, 0, 16'h0c0c, 0);
      step(4'h8, 0, 0, 0, 16'h8d0d);
      wait_done(1);
      // Address wrap.
      start_run(8'hFE, 3);
      repeat (3) step(4'hF, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      wait_done(3);
      // Lane 0 overrun keeps the first value.
      start_run(8'h20, 1);
      step(4'h1, 16'h0011, 0, 0, 0);
      step(4'h1, 16'h0022, 0, 0, 0);
      step(4'hE, 0, 16'h0033, 16'h0044, 16'h0055);
      wait_done(1);
      chk("ovf_sticky", overflow, 1);
      // Empty run.
      start_run(8'h30, 0);
      @(posedge clk); #1;
      chk("cnt0_done", done, 1);
      chk("cnt0_rows", rows_written, 0);
      @(posedge clk); #1;
      chk("cnt0_after", done, 0);
      chk("cnt0_idle", busy, 0);
      m_on = 0;
      // start while busy is ignored.
      start_run(8'h50, 2);
      start = 1; base_addr = 8'h99; row_count = 9'd5;
      step(4'hF, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
      start = 0;
      step(4'hF, 16'h0505, 16'h0606, 16'h0707, 16'h0808);
      wait_done(2);
      // Random runs, including skew, overruns and strobes past the last row.
      for (int r = 0; r < 6; r++) begin
         start_run(8'($urandom), $urandom_range(1, 6));
         rand_row_fill();
         wait_done(m_cnt);
      end
      // Reset mid-run aborts cleanly.
      start_run(8'h60, 4);
      repeat (3) step(4'hF, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      valid_in = 0;
      rst = 1;
      @(posedge clk); #1;
      q.delete();
      m_on = 0;
      chk("mid_rst_en", bram_en, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rows", rows_written, 0);
      chk("mid_rst_done", done, 0);
      rst = 0;
      @(posedge clk); #1;
      start_run(8'h70, 1);
      step(4'hF, 16'h7001, 16'h7002, 16'h7003, 16'h7004);
      wait_done(1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
